// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM states and the divide-by-zero quotient value.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

    function automatic logic op_is_signed(op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// The pipeline side is the master; the unit is the slave.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] rs_data_i;
    logic [WIDTH-1:0] rt_data_i;
    logic             kill_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, rs_data_i, rt_data_i, kill_i,
        input  busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, rs_data_i, rt_data_i, kill_i,
        output busy_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; used both to take operand magnitudes
// and to restore the sign of results.
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);
    assign dout = neg ? (~din + WIDTH'(1)) : din;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle on magnitudes,
// sign restoration in a single fix-up cycle, then HI/LO written.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk_i,
    input  logic     rst_i,
    muldiv_if.slave  bus
);
    localparam int ITERS = WIDTH;
    localparam int CW    = $clog2(ITERS) + 1;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    op_e                op_q;
    logic               sign_a_q, sign_b_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] acc_q, acc_step;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q;

    op_e                op_in;
    logic               in_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign op_in     = op_e'(bus.op_i);
    assign in_signed = op_is_signed(op_in);

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .din(bus.rs_data_i), .neg(in_signed & bus.rs_data_i[WIDTH-1]), .dout(a_mag)
    );
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .din(bus.rt_data_i), .neg(in_signed & bus.rt_data_i[WIDTH-1]), .dout(b_mag)
    );

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (bus.kill_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.start_i) state_d = CALC;
                CALC:    if (cnt_q == CW'(ITERS - 1)) state_d = FIX;
                FIX:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Multiply: acc = {partial sum, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        // The true difference is below the divisor, so WIDTH bits hold it.
        div_diff  = div_shift[WIDTH-1:0] - b_q;
        if (op_is_div(op_q)) begin
            acc_step = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed, rem_fixed;
    logic [WIDTH-1:0]   res_hi, res_lo;

    muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .din(acc_q), .neg(sign_a_q ^ sign_b_q), .dout(prod_fixed)
    );
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
        .din(acc_q[WIDTH-1:0]), .neg(sign_a_q ^ sign_b_q), .dout(quo_fixed)
    );
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .din(acc_q[2*WIDTH-1:WIDTH]), .neg(sign_a_q), .dout(rem_fixed)
    );

    // With a zero divisor the remainder path already reproduces the dividend;
    // only the quotient needs overriding.
    always_comb begin
        res_hi = prod_fixed[2*WIDTH-1:WIDTH];
        res_lo = prod_fixed[WIDTH-1:0];
        if (op_is_div(op_q)) begin
            res_hi = rem_fixed;
            res_lo = (b_q == '0) ? WIDTH'(DIV_ZERO_LO) : quo_fixed;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            op_q     <= OP_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && state_d == CALC) begin
                op_q     <= op_in;
                sign_a_q <= in_signed & bus.rs_data_i[WIDTH-1];
                sign_b_q <= in_signed & bus.rt_data_i[WIDTH-1];
                a_q      <= a_mag;
                b_q      <= b_mag;
                acc_q    <= op_is_div(op_in) ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                cnt_q    <= '0;
            end else if (state_q == CALC) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q + CW'(1);
            end
            if (state_q == FIX && !bus.kill_i) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
            busy_q <= (state_d != IDLE);
            done_q <= (state_q == FIX) && !bus.kill_i;
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized
// operations against an arithmetic reference model, and handshake corner cases.
module tb_muldiv_unit;
    logic clk;
    logic rst;
    int unsigned checks;
    int unsigned errors;
    int unsigned edge_cnt;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int unsigned acc_edge;
    } pend_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin sp = sa * sb; {hi, lo} = sp; end
            2'd1: begin up = ua * ub; {hi, lo} = up; end
            2'd2: begin
                if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
            end
            default: begin
                if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else begin up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0]; end
            end
        endcase
    endfunction

    // Issue one operation from idle and check latency, result and the done pulse.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        lat = -1;
        bus.start_i   = 1'b1;
        bus.op_i      = op;
        bus.rs_data_i = a;
        bus.rt_data_i = b;
        @(posedge clk);
        @(negedge clk);
        bus.start_i   = 1'b0;
        bus.rs_data_i = $urandom;
        bus.rt_data_i = $urandom;
        check({name, " busy"}, 64'(bus.busy_o), 64'd1);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done_o) begin
                lat = k;
                break;
            end
        end
        check({name, " latency"}, 64'(lat), 64'd33);
        check({name, " hi"}, 64'(bus.hi_o), 64'(exp_hi));
        check({name, " lo"}, 64'(bus.lo_o), 64'(exp_lo));
        check({name, " busy fall"}, 64'(bus.busy_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({name, " done pulse"}, 64'(bus.done_o), 64'd0);
    endtask

    initial begin
        vec_t        vecs[$];
        pend_t       pend[$];
        pend_t       p;
        logic [1:0]  op;
        logic [31:0] a, b, mh, ml;
        int          lat;
        int          dones;
        bit          done_seen;

        checks = 0;
        errors = 0;

        vecs.push_back('{"mult -2x3",      2'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
        vecs.push_back('{"multu max",      2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{"div -7/2",       2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{"divu 7/0",       2'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF});
        vecs.push_back('{"div overflow",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
        vecs.push_back('{"div -5/0",       2'd2, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF});
        vecs.push_back('{"mult min*min",   2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
        vecs.push_back('{"divu 100/7",     2'd3, 32'd100,       32'd7,         32'd2,         32'd14});
        vecs.push_back('{"div 7/-2",       2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
        vecs.push_back('{"mult 7x-1",      2'd0, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9});
        vecs.push_back('{"divu big/max",   2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000});

        rst           = 1'b1;
        bus.start_i   = 1'b0;
        bus.op_i      = 2'd0;
        bus.rs_data_i = '0;
        bus.rt_data_i = '0;
        bus.kill_i    = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(bus.busy_o), 64'd0);
        check("reset done", 64'(bus.done_o), 64'd0);
        check("reset hi",   64'(bus.hi_o),   64'd0);
        check("reset lo",   64'(bus.lo_o),   64'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            model(op, a, b, mh, ml);
            run_op($sformatf("rand%0d", i), op, a, b, mh, ml);
        end

        // A second start mid-operation must not disturb the running DIVU.
        lat = -1;
        bus.start_i = 1'b1; bus.op_i = 2'd3; bus.rs_data_i = 32'd100; bus.rt_data_i = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 10) begin
                bus.start_i = 1'b1; bus.op_i = 2'd0; bus.rs_data_i = 32'd3; bus.rt_data_i = 32'd5;
            end else begin
                bus.start_i = 1'b0;
            end
            if (bus.done_o) begin
                lat = k;
                break;
            end
        end
        bus.start_i = 1'b0;
        check("overlap latency", 64'(lat), 64'd33);
        check("overlap lo", 64'(bus.lo_o), 64'd14);
        check("overlap hi", 64'(bus.hi_o), 64'd2);
        @(negedge clk);

        // Kill during a MULT: busy drops, no done, HI/LO untouched.
        bus.start_i = 1'b1; bus.op_i = 2'd0; bus.rs_data_i = 32'd3; bus.rt_data_i = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (19) @(negedge clk);
        bus.kill_i = 1'b1;
        @(negedge clk);
        bus.kill_i = 1'b0;
        check("kill busy", 64'(bus.busy_o), 64'd0);
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done_o) done_seen = 1'b1;
        end
        check("kill no done", 64'(done_seen), 64'd0);
        check("kill hi", 64'(bus.hi_o), 64'd2);
        check("kill lo", 64'(bus.lo_o), 64'd14);

        // Kill together with start in idle: nothing starts.
        bus.start_i = 1'b1; bus.kill_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0; bus.kill_i = 1'b0;
        check("kill+start busy", 64'(bus.busy_o), 64'd0);

        // Asynchronous reset mid-CALC clears everything without a clock edge.
        bus.start_i = 1'b1; bus.op_i = 2'd1; bus.rs_data_i = 32'd9; bus.rt_data_i = 32'd9;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", 64'(bus.busy_o), 64'd0);
        check("async rst done", 64'(bus.done_o), 64'd0);
        check("async rst hi",   64'(bus.hi_o),   64'd0);
        check("async rst lo",   64'(bus.lo_o),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("multu 6x7", 2'd1, 32'd6, 32'd7, 32'd0, 32'd42);

        // start held high with fresh operands every cycle: each result must
        // belong to the operands present at its accepting edge.
        dones = 0;
        bus.start_i   = 1'b1;
        bus.op_i      = 2'($urandom_range(0, 3));
        bus.rs_data_i = $urandom;
        bus.rt_data_i = $urandom;
        pend.push_back('{bus.op_i, bus.rs_data_i, bus.rt_data_i, edge_cnt + 1});
        for (int c = 0; c < 200 && dones < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done_o) begin
                if (pend.size() == 0) begin
                    check("held unexpected done", 64'd1, 64'd0);
                end else begin
                    p = pend.pop_front();
                    model(p.op, p.a, p.b, mh, ml);
                    check($sformatf("held%0d hi", dones), 64'(bus.hi_o), 64'(mh));
                    check($sformatf("held%0d lo", dones), 64'(bus.lo_o), 64'(ml));
                    check($sformatf("held%0d latency", dones), 64'(edge_cnt - p.acc_edge), 64'd33);
                end
                dones++;
            end
            bus.op_i      = 2'($urandom_range(0, 3));
            bus.rs_data_i = $urandom;
            bus.rt_data_i = $urandom;
            if (bus.done_o) pend.push_back('{bus.op_i, bus.rs_data_i, bus.rt_data_i, edge_cnt + 1});
        end
        check("held done count", 64'(dones), 64'd4);
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b1;
        @(negedge clk);
        bus.kill_i  = 1'b0;
        check("held final idle", 64'(bus.busy_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
